// File: rtl/cmp_pkg.sv
// Shared types and helpers for the comparator self-test sweep controller.
// Also used by the bench as its reference comparator.
package cmp_pkg;

    localparam int OPW_DEFAULT = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Reference unsigned magnitude compare, packed as {lt, gt, eq}.
    function automatic logic [2:0] golden_cmp(input int unsigned a, input int unsigned b);
        return {a < b, a > b, a == b};
    endfunction

endpackage

// File: rtl/cmp_sweep_ctrl_if.sv
// Operand/result bus between the sweep controller (master) and the
// comparator under test (slave).
interface cmp_sweep_ctrl_if
    import cmp_pkg::*;
#(
    parameter int OPW = OPW_DEFAULT
);
    logic [OPW-1:0] a_out;
    logic [OPW-1:0] b_out;
    logic           lt_in;
    logic           gt_in;
    logic           eq_in;

    modport master (output a_out, b_out, input  lt_in, gt_in, eq_in);
    modport slave  (input  a_out, b_out, output lt_in, gt_in, eq_in);
endinterface

// File: rtl/cmp_settle_timer.sv
// Settle-time counter: clear/enable up-counter whose terminal count flags
// the last cycle of the operand hold window.
module cmp_settle_timer #(
    parameter int SETTLE_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    localparam int TW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // NOTE: give every combinationally written signal a default first so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = cnt_q + TW'(1);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign tc_o = (cnt_q == TW'(SETTLE_CYC - 1));

endmodule

// File: rtl/cmp_sweep_ctrl.sv
// Self-test sequencer: sweeps every {b,a} pair through the comparator,
// checks each sampled result against the golden compare, and tallies outcomes.
module cmp_sweep_ctrl
    import cmp_pkg::*;
#(
    parameter int OPW        = OPW_DEFAULT,
    parameter int SETTLE_CYC = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    cmp_sweep_ctrl_if.master     cmp,
    output logic                 busy,
    output logic                 done,
    output logic [2*OPW:0]       lt_cnt,
    output logic [2*OPW:0]       gt_cnt,
    output logic [2*OPW:0]       eq_cnt,
    output logic [2*OPW:0]       err_cnt,
    output logic                 err,
    output logic [2*OPW-1:0]     first_err_idx
);
    localparam int IW = 2 * OPW;
    localparam int CW = 2 * OPW + 1;

    state_e        state_q;
    state_e        state_d;
    logic [IW-1:0] idx_q;
    logic [CW-1:0] lt_cnt_q;
    logic [CW-1:0] gt_cnt_q;
    logic [CW-1:0] eq_cnt_q;
    logic [CW-1:0] err_cnt_q;
    logic          err_q;
    logic [IW-1:0] first_err_idx_q;

    logic          start_acc;
    logic          sample;
    logic          last_idx;
    logic          settle_tc;
    logic [2:0]    exp_res;
    logic [2:0]    obs_res;
    logic          mismatch;

    cmp_settle_timer #(.SETTLE_CYC(SETTLE_CYC)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (start_acc || sample),
        .en_i  ((state_q == ST_SETTLE) && !settle_tc),
        .tc_o  (settle_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start)     state_d = ST_SETTLE;
            ST_SETTLE:        if (settle_tc) state_d = ST_SAMPLE;
            ST_SAMPLE:        state_d = last_idx ? ST_DONE : ST_SETTLE;
            default:          state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
        done      = (state_q == ST_DONE);
        sample    = (state_q == ST_SAMPLE);
        start_acc = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    end

    assign last_idx = &idx_q;
    assign exp_res  = golden_cmp(32'(idx_q[OPW-1:0]), 32'(idx_q[IW-1:OPW]));
    assign obs_res  = {cmp.lt_in, cmp.gt_in, cmp.eq_in};
    assign mismatch = (obs_res != exp_res);

    // Counts are independent per input, so a non-one-hot result bumps several.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q           <= '0;
            lt_cnt_q        <= '0;
            gt_cnt_q        <= '0;
            eq_cnt_q        <= '0;
            err_cnt_q       <= '0;
            err_q           <= 1'b0;
            first_err_idx_q <= '0;
        end else if (start_acc) begin
            idx_q           <= '0;
            lt_cnt_q        <= '0;
            gt_cnt_q        <= '0;
            eq_cnt_q        <= '0;
            err_cnt_q       <= '0;
            err_q           <= 1'b0;
            first_err_idx_q <= '0;
        end else if (sample) begin
            lt_cnt_q <= lt_cnt_q + CW'(cmp.lt_in);
            gt_cnt_q <= gt_cnt_q + CW'(cmp.gt_in);
            eq_cnt_q <= eq_cnt_q + CW'(cmp.eq_in);
            if (mismatch) begin
                err_cnt_q <= err_cnt_q + CW'(1);
                if (!err_q) begin
                    err_q           <= 1'b1;
                    first_err_idx_q <= idx_q;
                end
            end
            // The final pair stays on the bus while DONE holds.
            if (!last_idx)
                idx_q <= idx_q + IW'(1);
        end
    end

    assign cmp.a_out     = idx_q[OPW-1:0];
    assign cmp.b_out     = idx_q[IW-1:OPW];
    assign lt_cnt        = lt_cnt_q;
    assign gt_cnt        = gt_cnt_q;
    assign eq_cnt        = eq_cnt_q;
    assign err_cnt       = err_cnt_q;
    assign err           = err_q;
    assign first_err_idx = first_err_idx_q;

endmodule

// File: tb/tb_cmp_sweep_ctrl.sv
// Bench for cmp_sweep_ctrl: behavioural comparator with fault modes, a
// scoreboard of expected {b,a} pairs, and end-of-sweep tally checks.
module tb_cmp_sweep_ctrl;
    import cmp_pkg::*;

    localparam int OPW        = 2;
    localparam int SETTLE_CYC = 4;
    localparam int IW         = 2 * OPW;
    localparam int CW         = 2 * OPW + 1;
    localparam int N          = 1 << IW;
    localparam int SWEEP_CYC  = N * (SETTLE_CYC + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic [CW-1:0] lt_cnt;
    logic [CW-1:0] gt_cnt;
    logic [CW-1:0] eq_cnt;
    logic [CW-1:0] err_cnt;
    logic          err;
    logic [IW-1:0] first_err_idx;

    int            checks = 0;
    int            errors = 0;
    int            fault_mode = 0;
    logic [IW-1:0] sb_q[$];

    always #5 clk = ~clk;

    cmp_sweep_ctrl_if #(.OPW(OPW)) bus ();

    cmp_sweep_ctrl #(.OPW(OPW), .SETTLE_CYC(SETTLE_CYC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .cmp           (bus),
        .busy          (busy),
        .done          (done),
        .lt_cnt        (lt_cnt),
        .gt_cnt        (gt_cnt),
        .eq_cnt        (eq_cnt),
        .err_cnt       (err_cnt),
        .err           (err),
        .first_err_idx (first_err_idx)
    );

    // Comparator model: 0 = correct, 1 = eq stuck at 0, 2 = lt and gt both 1 at {b,a}=5.
    always_comb begin
        logic [2:0] r;
        r = golden_cmp(32'(bus.a_out), 32'(bus.b_out));
        if (fault_mode == 1)
            r[0] = 1'b0;
        if (fault_mode == 2 && {bus.b_out, bus.a_out} == IW'(5))
            r[2:1] = 2'b11;
        bus.lt_in = r[2];
        bus.gt_in = r[1];
        bus.eq_in = r[0];
    end

    // Runs one sweep; optionally pulses start or asserts reset when a given index appears.
    task automatic run_sweep(input string name, input int start_at, input int rst_at,
                             output int cycles);
        logic [IW-1:0] exp_idx;
        logic [IW-1:0] last_ab;
        bit            first;
        bit            hit;
        cycles = 0;
        first  = 1'b1;
        last_ab = '0;
        sb_q.delete();
        for (int i = 0; i < N; i++) sb_q.push_back(IW'(i));
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        checks++;
        if ({busy, done, lt_cnt, gt_cnt, eq_cnt, err_cnt, err, first_err_idx} !== {1'b1, 1'b0, {(4*CW+1+IW){1'b0}}}) begin
            errors++;
            $display("FAIL %s start_clear: busy=%b done=%b cnt=%0d/%0d/%0d err_cnt=%0d err=%b fei=%0d, need busy=1 all else 0",
                     name, busy, done, lt_cnt, gt_cnt, eq_cnt, err_cnt, err, first_err_idx);
        end
        while (cycles < SWEEP_CYC + 40) begin
            if (busy && (first || {bus.b_out, bus.a_out} != last_ab)) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s pair_extra: got {b,a}=%0d, scoreboard empty", name, {bus.b_out, bus.a_out});
                end else begin
                    exp_idx = sb_q.pop_front();
                    if ({bus.b_out, bus.a_out} !== exp_idx) begin
                        errors++;
                        $display("FAIL %s pair_order: got {b,a}=%0d, need %0d", name, {bus.b_out, bus.a_out}, exp_idx);
                    end
                    hit = 1'b1;
                    if (int'(exp_idx) == start_at) start = 1'b1;
                    if (int'(exp_idx) == rst_at) begin
                        rst_n = 1'b0;
                        #1;
                        checks++;
                        if ({bus.a_out, bus.b_out, busy, done, lt_cnt, gt_cnt, eq_cnt, err_cnt, err, first_err_idx} !== '0) begin
                            errors++;
                            $display("FAIL %s async_reset: a=%0d b=%0d busy=%b done=%b cnt=%0d/%0d/%0d err_cnt=%0d err=%b fei=%0d, need all 0",
                                     name, bus.a_out, bus.b_out, busy, done, lt_cnt, gt_cnt, eq_cnt, err_cnt, err, first_err_idx);
                        end
                        @(negedge clk) rst_n = 1'b1;
                        sb_q.delete();
                        return;
                    end
                end
                first   = 1'b0;
                last_ab = {bus.b_out, bus.a_out};
            end
            if (done) break;
            @(negedge clk);
            start = 1'b0;
            cycles++;
        end
        checks++;
        if (!done || busy || sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s completion: done=%b busy=%b pairs_left=%0d after %0d cycles, need done=1 busy=0 pairs_left=0",
                     name, done, busy, sb_q.size(), cycles);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.a_out, bus.b_out, busy, done, lt_cnt, gt_cnt, eq_cnt, err_cnt, err, first_err_idx} !== '0) begin
            errors++;
            $display("FAIL reset_state: a=%0d b=%0d busy=%b done=%b cnt=%0d/%0d/%0d err_cnt=%0d err=%b, need all 0",
                     bus.a_out, bus.b_out, busy, done, lt_cnt, gt_cnt, eq_cnt, err_cnt, err);
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: busy=%b done=%b, need 0 0", busy, done);
        end
    endtask

    task automatic test_clean_sweep(input string name, input int start_at);
        int cyc;
        fault_mode = 0;
        run_sweep(name, start_at, -1, cyc);
        checks++;
        if (cyc != SWEEP_CYC) begin
            errors++;
            $display("FAIL %s done_latency: got %0d cycles, need %0d", name, cyc, SWEEP_CYC);
        end
        checks++;
        if ({lt_cnt, gt_cnt, eq_cnt, err_cnt, err, first_err_idx} !== {CW'(6), CW'(6), CW'(4), CW'(0), 1'b0, IW'(0)}) begin
            errors++;
            $display("FAIL %s tallies: lt=%0d gt=%0d eq=%0d err_cnt=%0d err=%b fei=%0d, need 6 6 4 0 0 0",
                     name, lt_cnt, gt_cnt, eq_cnt, err_cnt, err, first_err_idx);
        end
    endtask

    task automatic test_eq_stuck();
        int cyc;
        fault_mode = 1;
        run_sweep("eq_stuck", -1, -1, cyc);
        checks++;
        if ({lt_cnt, gt_cnt, eq_cnt, err_cnt, err, first_err_idx} !== {CW'(6), CW'(6), CW'(0), CW'(4), 1'b1, IW'(0)}) begin
            errors++;
            $display("FAIL eq_stuck tallies: lt=%0d gt=%0d eq=%0d err_cnt=%0d err=%b fei=%0d, need 6 6 0 4 1 0",
                     lt_cnt, gt_cnt, eq_cnt, err_cnt, err, first_err_idx);
        end
    endtask

    task automatic test_double_hot();
        int cyc;
        fault_mode = 2;
        run_sweep("double_hot", -1, -1, cyc);
        checks++;
        if ({lt_cnt, gt_cnt, eq_cnt, err_cnt, err, first_err_idx} !== {CW'(7), CW'(7), CW'(4), CW'(1), 1'b1, IW'(5)}) begin
            errors++;
            $display("FAIL double_hot tallies: lt=%0d gt=%0d eq=%0d err_cnt=%0d err=%b fei=%0d, need 7 7 4 1 1 5",
                     lt_cnt, gt_cnt, eq_cnt, err_cnt, err, first_err_idx);
        end
        repeat (5) @(negedge clk);
        checks++;
        if ({done, busy, bus.b_out, bus.a_out} !== {1'b1, 1'b0, IW'(N - 1)}) begin
            errors++;
            $display("FAIL done_hold: done=%b busy=%b {b,a}=%0d, need 1 0 %0d", done, busy, {bus.b_out, bus.a_out}, N - 1);
        end
    endtask

    task automatic test_mid_reset();
        int cyc;
        fault_mode = 0;
        run_sweep("mid_reset", -1, 9, cyc);
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset idle: busy=%b done=%b, need 0 0", busy, done);
        end
        test_clean_sweep("after_reset", -1);
    endtask

    initial begin
        test_reset();
        test_clean_sweep("clean", -1);
        test_eq_stuck();
        test_double_hot();
        test_clean_sweep("restart_clears", -1);
        test_clean_sweep("start_ignored", 7);
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmp_sweep_ctrl.md
Name: cmp_sweep_ctrl

Overview:
Self-test sequencer wrapped around the ROM-based magnitude comparator. It drives every operand pair {b,a} into the comparator in ascending address order and waits a programmable settle time. It then samples Lt/Gt/Eq, checks them against an internal golden compare, and accumulates per-outcome and error counts for display on board LEDs/7-seg.

Parameters:
OPW, 2, operand width in bits; sweep length N = 2^(2*OPW) (16 at default)
SETTLE_CYC, 4, clock cycles operands are held stable before sampling; must be >= 1

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
start  input  1  single-cycle pulse; starts a sweep from IDLE or DONE
a_out  output  OPW  operand a to comparator
b_out  output  OPW  operand b to comparator
lt_in  input  1  comparator Lt result
gt_in  input  1  comparator Gt result
eq_in  input  1  comparator Eq result
busy  output  1  high while a sweep is in progress
done  output  1  high from sweep completion until next start or reset
lt_cnt  output  2*OPW+1  number of sampled Lt results
gt_cnt  output  2*OPW+1  number of sampled Gt results
eq_cnt  output  2*OPW+1  number of sampled Eq results
err_cnt  output  2*OPW+1  number of mismatching samples
err  output  1  sticky; set on the first mismatch of a sweep
first_err_idx  output  2*OPW  sweep index of the first mismatch; valid when err=1

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n). The reset state applies immediately on assertion, and release is synchronous to clk.
- Reset values: state IDLE, idx 0, a_out 0, b_out 0, busy 0, done 0, all counts 0, err 0, first_err_idx 0, settle timer 0.
- Index mapping: idx[2*OPW-1:0]; a_out = idx[OPW-1:0], b_out = idx[2*OPW-1:OPW]. This matches comparator address {b,a}. a_out/b_out are registered straight from idx.
- States:
  - IDLE: busy=0. On start, go to SETTLE. In the same edge, clear counts, err, first_err_idx and done, and set idx=0 and timer=0.
  - SETTLE: busy=1. Timer increments each cycle. When timer==SETTLE_CYC-1, go to SAMPLE.
  - SAMPLE (one cycle): busy=1.
    - Register lt_in/gt_in/eq_in. Increment each count whose input is 1; counts are independent, so a non-one-hot input increments several.
    - Golden result: exp_lt = a<b, exp_gt = a>b, exp_eq = a==b (unsigned).
    - Mismatch = any bit differs from golden. This covers non-one-hot and all-zero inputs.
    - On mismatch: err_cnt+1. If err was 0, set err and capture first_err_idx=idx.
    - If idx==N-1, go to DONE. Otherwise idx+1, timer=0, go to SETTLE.
  - DONE: busy=0, done=1. All outputs hold, and a_out/b_out keep the last pair. On start, same action as start in IDLE.
- start while busy (SETTLE or SAMPLE) is ignored.
- Latency: sweep occupies N*(SETTLE_CYC+1) cycles. done rises on the edge after the last SAMPLE cycle. At defaults, done is first high 80 cycles after the start edge.
- Counts cannot overflow: maximum is N, held in 2*OPW+1 bits. No wrap logic is required.
- Reset asserted mid-sweep: everything returns to reset values at once. A partial sweep leaves no residue.

Decomposition:
- Shared package cmp_pkg holds:
  - state enum constants ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE (2-bit encoding)
  - OPW default
  - golden compare function returning {lt,gt,eq}, reused by the testbench scoreboard
- One natural sub-module, cmp_settle_timer: clear/enable counter with terminal-count output at SETTLE_CYC-1. The FSM and accumulators stay in the top.

Test Plan:
- Correct comparator instance attached, start pulse → a/b step 00/00, 01/00 … 11/11. Final lt_cnt=6, gt_cnt=6, eq_cnt=4, err_cnt=0, err=0. done first high 80 cycles after start.
- eq_in forced 0 → err_cnt=4, err=1, first_err_idx=0, eq_cnt=0, lt_cnt=6, gt_cnt=6.
- lt_in and gt_in forced 1 only at idx 5 (a=1,b=1) → err_cnt=1, first_err_idx=5, lt_cnt=7, gt_cnt=7, eq_cnt=4.
- start pulsed again at idx 7 of a running sweep → ignored; sweep completes normally, counts 6/6/4.
- rst_n low for 1 cycle at idx 9 → all outputs 0 immediately, state IDLE. Next start gives a full clean sweep with counts 6/6/4.
- From DONE with err=1, start with a correct comparator → counts, err and first_err_idx cleared on the start edge. Final err=0.
